// File: rtl/seg_display_monitor.sv
// seg_display_monitor
// Passive observer for the microwave display interface. Decodes the three
// seven-segment digit buses back to BCD and total seconds, tracks the
// cooking phases from mag_on, and checks that the countdown steps down by
// exactly one second roughly every TICK_CYCLES clocks.
// Build option: define ERR_CNT_EN to build the saturating err_count event
// counter. Without it, err_count is tied to zero.
`timescale 1ns/1ps
module seg_display_monitor #(
    parameter int TICK_CYCLES = 100,
    parameter int TICK_TOL    = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] smin,
    input  logic [6:0] ssec_tens,
    input  logic [6:0] ssec_ones,
    input  logic       mag_on,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic [9:0] total_sec,
    output logic       digits_valid,
    output logic       tick,
    output logic       done,
    output logic       seg_err,
    output logic       step_err,
    output logic       rate_err,
    output logic [7:0] err_count
);

    localparam logic [CNT_W-1:0] TICK_LO = CNT_W'(TICK_CYCLES - TICK_TOL);
    localparam logic [CNT_W-1:0] TICK_HI = CNT_W'(TICK_CYCLES + TICK_TOL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COOK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    // Segment order is {a,b,c,d,e,f,g}; result is {legal, bcd}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   seg_decode = {1'b1, 4'd0};
            7'h30:   seg_decode = {1'b1, 4'd1};
            7'h6D:   seg_decode = {1'b1, 4'd2};
            7'h79:   seg_decode = {1'b1, 4'd3};
            7'h33:   seg_decode = {1'b1, 4'd4};
            7'h5B:   seg_decode = {1'b1, 4'd5};
            7'h5F:   seg_decode = {1'b1, 4'd6};
            7'h70:   seg_decode = {1'b1, 4'd7};
            7'h7F:   seg_decode = {1'b1, 4'd8};
            7'h7B:   seg_decode = {1'b1, 4'd9};
            default: seg_decode = 5'd0;
        endcase
    endfunction

    // Stage 1 registers
    logic [6:0] r_smin;
    logic [6:0] r_stens;
    logic [6:0] r_sones;
    logic       r_mag;
    logic       r_s1_vld;

    // Stage 2 / output registers; r_total doubles as prev_total
    logic [3:0] r_min;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic [9:0] r_total;
    logic       r_dvalid;
    logic       r_tick;
    logic       r_done;
    logic       r_seg_err;
    logic       r_step_err;
    logic       r_rate_err;

    // Phase tracking
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;
    logic             r_sat_seen;

    // Decode of the stage-1 digits
    logic [4:0]       w_min_dec;
    logic [4:0]       w_tens_dec;
    logic [4:0]       w_ones_dec;
    logic             w_valid;
    logic             w_seg_bad;
    logic [9:0]       w_total;
    logic             w_changed;
    logic             w_is_dec;
    logic             w_eff_zero;
    logic [CNT_W-1:0] w_interval;

    // FSM decisions
    logic w_tick;
    logic w_done;
    logic w_step_bad;
    logic w_rate_bad;
    logic w_enter_cook;
    logic w_sat_hit;

    // Capture raw inputs; r_s1_vld keeps the reset-zero stage from being
    // mistaken for an illegal segment pattern.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_smin   <= '0;
            r_stens  <= '0;
            r_sones  <= '0;
            r_mag    <= 1'b0;
            r_s1_vld <= 1'b0;
        end else begin
            r_smin   <= smin;
            r_stens  <= ssec_tens;
            r_sones  <= ssec_ones;
            r_mag    <= mag_on;
            r_s1_vld <= 1'b1;
        end
    end

    assign w_min_dec  = seg_decode(r_smin);
    assign w_tens_dec = seg_decode(r_stens);
    assign w_ones_dec = seg_decode(r_sones);

    assign w_valid   = r_s1_vld && w_min_dec[4] && w_ones_dec[4]
                       && w_tens_dec[4] && (w_tens_dec[3:0] <= 4'd5);
    assign w_seg_bad = r_s1_vld && !w_valid;

    assign w_total = ({6'd0, w_min_dec[3:0]}  * 10'd60)
                   + ({6'd0, w_tens_dec[3:0]} * 10'd10)
                   +  {6'd0, w_ones_dec[3:0]};

    // prev_total - 1 wraps to 1023 at zero, which no legal display reaches.
    assign w_changed  = w_valid && (w_total != r_total);
    assign w_is_dec   = w_valid && (w_total == r_total - 10'd1);
    assign w_eff_zero = w_valid ? (w_total == 10'd0) : (r_total == 10'd0);
    assign w_interval = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state and per-cycle event decisions for the cooking phases
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path leaves a signal unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_tick       = 1'b0;
        w_done       = 1'b0;
        w_step_bad   = 1'b0;
        w_rate_bad   = 1'b0;
        w_enter_cook = 1'b0;
        w_sat_hit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_mag) begin
                    w_state_nxt  = ST_COOK;
                    w_enter_cook = 1'b1;
                end
            end
            ST_COOK: begin
                if (w_is_dec) begin
                    w_tick = 1'b1;
                    if (!r_first && ((w_interval < TICK_LO) || (w_interval > TICK_HI)))
                        w_rate_bad = 1'b1;
                end else if (w_changed) begin
                    w_step_bad = 1'b1;
                end
                if (!w_is_dec && !r_sat_seen && (&w_interval)) begin
                    w_sat_hit  = 1'b1;
                    w_rate_bad = 1'b1;
                end
                // A tick in this same cycle has already moved the effective
                // total, so the mag_on fall sees the decremented value.
                if (!r_mag) begin
                    if (w_eff_zero) begin
                        w_state_nxt = ST_DONE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_changed && (w_total != 10'd0))
                    w_step_bad = 1'b1;
                if (r_mag) begin
                    w_state_nxt  = ST_COOK;
                    w_enter_cook = 1'b1;
                end else if (w_changed && (w_total == 10'd0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, interval counter and first-interval / saturation bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_sat_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enter_cook) begin
                r_cnt      <= '0;
                r_first    <= 1'b1;
                r_sat_seen <= 1'b0;
            end else if (r_state == ST_COOK) begin
                if (w_tick) begin
                    r_cnt   <= '0;
                    r_first <= 1'b0;
                end else begin
                    r_cnt <= w_interval;
                end
                if (w_sat_hit)
                    r_sat_seen <= 1'b1;
            end
        end
    end

    // Decoded outputs (held on illegal patterns), pulses and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_min      <= '0;
            r_tens     <= '0;
            r_ones     <= '0;
            r_total    <= '0;
            r_dvalid   <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_seg_err  <= 1'b0;
            r_step_err <= 1'b0;
            r_rate_err <= 1'b0;
        end else begin
            r_dvalid <= w_valid;
            if (w_valid) begin
                r_min   <= w_min_dec[3:0];
                r_tens  <= w_tens_dec[3:0];
                r_ones  <= w_ones_dec[3:0];
                r_total <= w_total;
            end
            r_tick <= w_tick;
            r_done <= w_done;
            if (w_seg_bad)  r_seg_err  <= 1'b1;
            if (w_step_bad) r_step_err <= 1'b1;
            if (w_rate_bad) r_rate_err <= 1'b1;
        end
    end

`ifdef ERR_CNT_EN
    logic       w_any_err;
    logic [7:0] r_err_cnt;

    assign w_any_err = w_seg_bad || w_step_bad || w_rate_bad;

    // One increment per cycle with any error event, saturating at 255
    always_ff @(posedge clock) begin
        if (reset)
            r_err_cnt <= '0;
        else if (w_any_err && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'd0;
`endif

    assign min_bcd      = r_min;
    assign sec_tens_bcd = r_tens;
    assign sec_ones_bcd = r_ones;
    assign total_sec    = r_total;
    assign digits_valid = r_dvalid;
    assign tick         = r_tick;
    assign done         = r_done;
    assign seg_err      = r_seg_err;
    assign step_err     = r_step_err;
    assign rate_err     = r_rate_err;

endmodule

// File: tb/tb_seg_display_monitor.sv
// tb_seg_display_monitor
// Scoreboard bench: every driven cycle pushes the expected decoded outputs,
// which are popped and compared when they emerge two cycles later. Flags,
// tick/done counts and err_count are checked at phase boundaries.
`timescale 1ns/1ps
module tb_seg_display_monitor;

`ifdef ERR_CNT_EN
    localparam bit ECNT = 1'b1;
`else
    localparam bit ECNT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] smin      = 7'h7E;
    logic [6:0] ssec_tens = 7'h7E;
    logic [6:0] ssec_ones = 7'h7E;
    logic       mag_on    = 1'b0;

    logic [3:0] min_bcd;
    logic [3:0] sec_tens_bcd;
    logic [3:0] sec_ones_bcd;
    logic [9:0] total_sec;
    logic       digits_valid;
    logic       tick;
    logic       done;
    logic       seg_err;
    logic       step_err;
    logic       rate_err;
    logic [7:0] err_count;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_tick = 0;
    int n_done = 0;
    int tick_base;

    bit          sb_on = 1'b0;
    logic [22:0] sb_q[$];
    logic [22:0] sb_exp;

    logic [3:0] hold_min   = '0;
    logic [3:0] hold_tens  = '0;
    logic [3:0] hold_ones  = '0;
    logic [9:0] hold_total = '0;
    int         cur_sec = 0;
    logic       cur_mag = 1'b0;

    seg_display_monitor dut (
        .clock        (clock),
        .reset        (reset),
        .smin         (smin),
        .ssec_tens    (ssec_tens),
        .ssec_ones    (ssec_ones),
        .mag_on       (mag_on),
        .min_bcd      (min_bcd),
        .sec_tens_bcd (sec_tens_bcd),
        .sec_ones_bcd (sec_ones_bcd),
        .total_sec    (total_sec),
        .digits_valid (digits_valid),
        .tick         (tick),
        .done         (done),
        .seg_err      (seg_err),
        .step_err     (step_err),
        .rate_err     (rate_err),
        .err_count    (err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: enc = 7'h7E;  1: enc = 7'h30;  2: enc = 7'h6D;  3: enc = 7'h79;
            4: enc = 7'h33;  5: enc = 7'h5B;  6: enc = 7'h5F;  7: enc = 7'h70;
            8: enc = 7'h7F;  9: enc = 7'h7B;  default: enc = 7'h00;
        endcase
    endfunction

    function automatic int dec(input logic [6:0] s);
        case (s)
            7'h7E: return 0;  7'h30: return 1;  7'h6D: return 2;  7'h79: return 3;
            7'h33: return 4;  7'h5B: return 5;  7'h5F: return 6;  7'h70: return 7;
            7'h7F: return 8;  7'h7B: return 9;  default: return -1;
        endcase
    endfunction

    // One clock: drive new inputs just after the edge and queue the outputs
    // they should produce two edges later.
    task automatic cycle(input logic [6:0] m, input logic [6:0] t,
                         input logic [6:0] o, input logic mag);
        int dm, dt, d_o;
        @(posedge clock);
        #1;
        smin = m;  ssec_tens = t;  ssec_ones = o;  mag_on = mag;
        dm = dec(m);  dt = dec(t);  d_o = dec(o);
        if (dm >= 0 && dt >= 0 && dt <= 5 && d_o >= 0) begin
            hold_min   = 4'(dm);
            hold_tens  = 4'(dt);
            hold_ones  = 4'(d_o);
            hold_total = 10'(dm * 60 + dt * 10 + d_o);
            sb_q.push_back({1'b1, hold_min, hold_tens, hold_ones, hold_total});
        end else begin
            sb_q.push_back({1'b0, hold_min, hold_tens, hold_ones, hold_total});
        end
    endtask

    task automatic show(input int sec, input logic mag);
        cur_sec = sec;
        cur_mag = mag;
        cycle(enc(sec / 60), enc((sec % 60) / 10), enc(sec % 10), mag);
    endtask

    task automatic hold(input int n);
        repeat (n) show(cur_sec, cur_mag);
    endtask

    // Output side of the scoreboard plus pulse counters
    always @(negedge clock) begin
        if (sb_on && sb_q.size() >= 3) begin
            sb_exp = sb_q.pop_front();
            check("pipe", {9'd0, digits_valid, min_bcd, sec_tens_bcd, sec_ones_bcd, total_sec},
                  {9'd0, sb_exp});
        end
        if (!reset) begin
            if (tick === 1'b1) n_tick++;
            if (done === 1'b1) n_done++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with 0:00 on the display: everything reads zero
        repeat (3) begin
            @(negedge clock);
            check("reset", {tick, done, seg_err, step_err, rate_err, digits_valid,
                            err_count, total_sec, min_bcd, sec_tens_bcd, sec_ones_bcd}, 32'd0);
        end
        reset = 1'b0;
        sb_on = 1'b1;
        show(0, 1'b0);
        hold(3);
        check("rst_dv", {31'd0, digits_valid}, 32'd1);

        // Key entry 1:28 while idle
        show(88, 1'b0);
        hold(4);
        check("entry_flags", {29'd0, seg_err, step_err, rate_err}, 32'd0);

        // Full countdown 1:28 -> 0:00 at 100 cycles per second
        tick_base = n_tick;
        show(88, 1'b1);
        for (int v = 87; v >= 0; v--) begin
            hold(99);
            show(v, 1'b1);
        end
        hold(10);
        show(0, 1'b0);
        hold(5);
        check("cook_ticks", 32'(n_tick - tick_base), 32'd88);
        check("cook_done", 32'(n_done), 32'd1);
        check("cook_flags", {29'd0, seg_err, step_err, rate_err}, 32'd0);
        check("cook_ecnt", {24'd0, err_count}, 32'd0);

        // Back in IDLE: a free jump to 0:50 is not a step error
        show(50, 1'b0);
        hold(3);
        check("idle_free", {31'd0, step_err}, 32'd0);

        // Fast interval of 90 cycles after a checked tick
        tick_base = n_tick;
        show(50, 1'b1);
        hold(99);  show(49, 1'b1);
        hold(99);  show(48, 1'b1);
        hold(89);  show(47, 1'b1);
        hold(4);
        check("fast_rate", {30'd0, step_err, rate_err}, 32'd1);
        check("fast_ticks", 32'(n_tick - tick_base), 32'd3);
        check("fast_ecnt", {24'd0, err_count}, ECNT ? 32'd1 : 32'd0);

        // Jump 0:45 -> 0:43 mid-cook: step error, no tick
        hold(99);  show(46, 1'b1);
        hold(99);  show(45, 1'b1);
        hold(99);  show(43, 1'b1);
        hold(4);
        check("jump_step", {31'd0, step_err}, 32'd1);
        check("jump_ticks", 32'(n_tick - tick_base), 32'd5);
        check("jump_ecnt", {24'd0, err_count}, ECNT ? 32'd2 : 32'd0);

        // Stop at 0:43 (pause, no done), then clear to 0:00
        show(43, 1'b0);
        hold(3);
        show(0, 1'b0);
        hold(3);
        check("pause_done", 32'(n_done), 32'd1);
        check("pause_ecnt", {24'd0, err_count}, ECNT ? 32'd2 : 32'd0);

        // Illegal patterns while idle at 1:28; the scoreboard expects the
        // held BCD values and digits_valid low on those cycles.
        show(88, 1'b0);
        hold(3);
        cycle(enc(1), 7'h5F, enc(8), 1'b0);
        show(88, 1'b0);
        hold(2);
        cycle(enc(1), enc(2), 7'h00, 1'b0);
        show(88, 1'b0);
        hold(4);
        check("seg_flags", {29'd0, seg_err, step_err, rate_err}, 32'd7);
        check("seg_ecnt", {24'd0, err_count}, ECNT ? 32'd4 : 32'd0);

        // Reset in the middle of a cook: everything clears, no done pulse
        show(30, 1'b1);
        hold(20);
        sb_on = 1'b0;
        sb_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_cook", {tick, done, seg_err, step_err, rate_err, digits_valid,
                           err_count, total_sec, min_bcd, sec_tens_bcd, sec_ones_bcd}, 32'd0);
        check("rst_nodone", 32'(n_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
